mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the computer's single 12-bit-address, 3-bit-data memory port between
//  three requesters: 0 = external loader/debug, 1 = data/stack (A/B), 2 = fetch (I/J).
//  Round-robin arbitration gives one access at a time. Each access is issued as one
//  memory-enable cycle. Read data is returned to the winning requester only.
//  A halt input (driven from H_F) freezes new grants and lets in-flight accesses finish.
// PARAMETERS
//  ADDR_W   12  address width
//  DATA_W    3  data width
//  MEM_LAT   1  memory read latency in cycles; legal range 1..7
// PORTS
//  clk        in   1               system clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  halt       in   1               1 = issue no new grants
//  req        in   3               per-requester access request
//  we         in   3               per-requester write enable (1 = write)
//  addr_in    in   3*ADDR_W        requester i address in [i*ADDR_W +: ADDR_W]
//  wdata_in   in   3*DATA_W        requester i write data in [i*DATA_W +: DATA_W]
//  gnt        out  3               one-hot grant, 1-cycle pulse
//  rvalid     out  3               one-hot read-data-valid, 1-cycle pulse
//  rdata      out  DATA_W          read data, qualified by rvalid
//  busy       out  1               1 when state != IDLE
//  mem_en     out  1               memory access strobe
//  mem_we     out  1               memory write strobe
//  mem_addr   out  ADDR_W          memory address
//  mem_wdata  out  DATA_W          memory write data
//  mem_rdata  in   DATA_W          memory read data
// BEHAVIOUR
//  Reset: all outputs are 0, state = IDLE, round-robin pointer ptr = 0, cnt = 0.
//  Address/data/we/owner registers are cleared to 0.
//  FSM: IDLE -> ISSUE -> (read) WAIT -> IDLE; (write) ISSUE -> IDLE.
//  IDLE:
//   - If halt = 0 and req != 0, the winner is the first set bit of req searched
//     in the order ptr, ptr+1, ptr+2 (mod 3).
//   - At the clock edge, latch owner, addr, wdata and we of the winner.
//     Then set ptr = (owner+1) mod 3 and go to ISSUE.
//  ISSUE (exactly 1 cycle):
//   - mem_en = 1, mem_we = latched we, gnt[owner] = 1.
//   - mem_addr and mem_wdata show the latched values.
//   - Write: next state is IDLE.
//   - Read: load cnt = MEM_LAT, next state is WAIT.
//  WAIT:
//   - cnt decrements each cycle. mem_rdata is valid in the cycle where cnt == 1.
//   - At that edge, register mem_rdata into rdata, pulse rvalid[owner] for the
//     next cycle, and go to IDLE.
//  Decoded outputs:
//   - mem_en, mem_we and gnt are decoded only from registered state, so they are
//     glitch-free.
//   - Outside ISSUE, mem_en = mem_we = gnt = 0.
//   - mem_addr and mem_wdata hold their last latched values.
//   - rdata holds its value until the next read completes.
//  Timing (MEM_LAT = 1, req sampled in cycle 0):
//   - Write: gnt in cycle 1; arbiter back in IDLE in cycle 2.
//   - Read: gnt in cycle 1, rvalid in cycle 3.
//   - Read latency from sample to rvalid is MEM_LAT+2 cycles.
//   - The IDLE cycle that carries rvalid may already arbitrate the next request.
//  Handshake:
//   - A requester holds req, we, addr and wdata stable until its gnt pulse.
//   - The access is committed when the arbiter latches in IDLE. Dropping req
//     after that does not cancel it.
//   - A requester that keeps req high after gnt is treated as a new request.
//  Simultaneous events:
//   - halt is sampled only in IDLE. Asserting halt during ISSUE/WAIT does not
//     abort the access; rvalid still pulses.
//   - req edges arriving during ISSUE/WAIT wait for the next IDLE.
//  Fairness: any requester held high is granted within 3 accesses (no starvation).
//  Reset mid-access: the access is abandoned immediately. No rvalid pulses,
//  mem_en drops asynchronously, and ptr returns to 0.
// TESTING
//  1. rst_n = 0 with random inputs -> all outputs 0, busy = 0. After release with
//     req = 0, nothing changes.
//  2. Read, req = 3'b010, addr_in[1] = 12'h123, memory returns 3'b101 ->
//     cycle 1: gnt = 010, mem_en = 1, mem_we = 0, mem_addr = 12'h123;
//     cycle 3: rvalid = 010, rdata = 3'b101.
//  3. req = 3'b111, all writes, held high -> grants 001, 010, 100, 001... every
//     2 cycles; mem_wdata matches each owner.
//  4. Read in flight, then halt = 1 in WAIT -> rvalid still pulses; no gnt while
//     halt = 1. After halt = 0 the next grant follows ptr.
//  5. rst_n pulsed low during WAIT -> mem_en = 0 at once, no rvalid. After release,
//     req = 3'b110 grants requester 1 (ptr = 0).
//  6. MEM_LAT = 3 read -> gnt in cycle 1, WAIT in cycles 2-4, rvalid and data from
//     the memory model in cycle 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between three
// requesters (0 = loader/debug, 1 = data/stack, 2 = fetch). Each granted access
// is one memory-enable cycle; reads wait MEM_LAT cycles for mem_rdata and return
// it to the owner with a one-cycle rvalid pulse. halt blocks new grants only.
module mem_port_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 3,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  halt,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr_in,
   input  logic [3*DATA_W-1:0]   wdata_in,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Latency counter is 3 bits wide, which covers the legal MEM_LAT range 1..7.
   localparam logic [2:0] LAT = 3'(MEM_LAT);

   state_t            state;
   logic [1:0]        ptr;
   logic [1:0]        owner;
   logic [2:0]        cnt;

   logic [1:0]        win;
   logic              win_valid;
   logic [1:0]        cand1;
   logic [1:0]        cand2;
   logic [ADDR_W-1:0] addr_arr  [3];
   logic [DATA_W-1:0] wdata_arr [3];

   // Requester index after p, wrapping 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Split the flattened request buses into per-requester views.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         addr_arr[i]  = addr_in[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = wdata_in[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin winner: first set request bit in the order ptr, ptr+1, ptr+2.
   // NOTE: every output of this block gets a default up front, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      cand1     = rr_next(ptr);
      cand2     = rr_next(cand1);
      win       = ptr;
      win_valid = 1'b0;
      if (!halt) begin
         if (req[ptr]) begin
            win       = ptr;
            win_valid = 1'b1;
         end else if (req[cand1]) begin
            win       = cand1;
            win_valid = 1'b1;
         end else if (req[cand2]) begin
            win       = cand2;
            win_valid = 1'b1;
         end
      end
   end

   // Access FSM; grant and strobes are registered so they come straight off flops.
   // NOTE: all state here uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         owner     <= 2'd0;
         cnt       <= 3'd0;
         gnt       <= 3'b000;
         rvalid    <= 3'b000;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Pulse outputs default low; only the cycle that sets them raises them.
         gnt    <= 3'b000;
         rvalid <= 3'b000;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  owner     <= win;
                  mem_addr  <= addr_arr[win];
                  mem_wdata <= wdata_arr[win];
                  mem_we    <= we[win];
                  mem_en    <= 1'b1;
                  gnt       <= 3'b001 << win;
                  ptr       <= rr_next(win);
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // mem_we still carries the latched direction during ISSUE.
               if (mem_we) begin
                  state <= IDLE;
               end else begin
                  cnt   <= LAT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  rdata  <= mem_rdata;
                  rvalid <= 3'b001 << owner;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // busy decodes straight from the state register.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven bench for mem_port_arbiter.
// dut uses MEM_LAT = 1, dut3 uses MEM_LAT = 3. Each memory model returns
// addr[2:0] ^ 3'b110 as read data, and drives 0 outside the valid cycle.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;

   // MEM_LAT = 1 instance signals
   logic        halt;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [35:0] addr_in;
   logic [8:0]  wdata_in;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [2:0]  rdata;
   logic        busy;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [2:0]  mem_wdata;
   logic [2:0]  mem_rdata;

   // MEM_LAT = 3 instance signals
   logic        halt3;
   logic [2:0]  req3;
   logic [2:0]  we3;
   logic [35:0] addr_in3;
   logic [8:0]  wdata_in3;
   logic [2:0]  gnt3;
   logic [2:0]  rvalid3;
   logic [2:0]  rdata3;
   logic        busy3;
   logic        mem_en3;
   logic        mem_we3;
   logic [11:0] mem_addr3;
   logic [2:0]  mem_wdata3;
   logic [2:0]  mem_rdata3;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(3), .MEM_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt), .req(req), .we(we),
      .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(3), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .halt(halt3), .req(req3), .we(we3),
      .addr_in(addr_in3), .wdata_in(wdata_in3), .gnt(gnt3), .rvalid(rvalid3),
      .rdata(rdata3), .busy(busy3), .mem_en(mem_en3), .mem_we(mem_we3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model, latency 1
   logic       rd1_v;
   logic [2:0] rd1_d;
   always @(posedge clk) begin
      rd1_v <= mem_en && !mem_we;
      rd1_d <= mem_addr[2:0] ^ 3'b110;
   end
   assign mem_rdata = rd1_v ? rd1_d : 3'b000;

   // Memory model, latency 3
   logic [2:0] rd3_v;
   logic [2:0] rd3_d [3];
   always @(posedge clk) begin
      rd3_v    <= {rd3_v[1:0], mem_en3 && !mem_we3};
      rd3_d[0] <= mem_addr3[2:0] ^ 3'b110;
      rd3_d[1] <= rd3_d[0];
      rd3_d[2] <= rd3_d[1];
   end
   assign mem_rdata3 = rd3_v[2] ? rd3_d[2] : 3'b000;

   typedef struct {
      logic        halt;
      logic [2:0]  req;
      logic [2:0]  we;
      logic [2:0]  gnt;
      logic [2:0]  rvalid;
      logic [2:0]  rdata;
      logic        busy;
      logic        en;
      logic        wr;
      logic [11:0] addr;
      logic [2:0]  wdata;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(input logic h, input logic [2:0] r, input logic [2:0] w,
                               input logic [2:0] g, input logic [2:0] rv, input logic [2:0] rd,
                               input logic b, input logic e, input logic mw,
                               input logic [11:0] a, input logic [2:0] wd);
      vec_t v;
      v.halt = h; v.req = r; v.we = w; v.gnt = g; v.rvalid = rv; v.rdata = rd;
      v.busy = b; v.en = e; v.wr = mw; v.addr = a; v.wdata = wd;
      return v;
   endfunction

   function automatic logic [26:0] pack(input logic [2:0] g, input logic [2:0] rv,
                                        input logic [2:0] rd, input logic b, input logic e,
                                        input logic mw, input logic [11:0] a,
                                        input logic [2:0] wd);
      return {g, rv, rd, b, e, mw, a, wd};
   endfunction

   function automatic logic [26:0] obs1();
      return pack(gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata);
   endfunction

   function automatic logic [26:0] obs3();
      return pack(gnt3, rvalid3, rdata3, busy3, mem_en3, mem_we3, mem_addr3, mem_wdata3);
   endfunction

   task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fixed request payloads: addr {FFF,123,00A}, wdata {110,101,011}.
      addr_in   = {12'hFFF, 12'h123, 12'h00A};
      wdata_in  = {3'b110, 3'b101, 3'b011};
      addr_in3  = {12'h000, 12'h000, 12'h055};
      wdata_in3 = 9'd0;
      halt = 1'b0; req = 3'b000; we = 3'b000;
      halt3 = 1'b0; req3 = 3'b000; we3 = 3'b000;
      rst_n = 1'b0;

      // Vectors: inputs for a cycle, expected outputs of the following cycle.
      vecs[0]  = mk(0, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 1, 1, 0, 12'h123, 3'b101);
      vecs[1]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0, 12'h123, 3'b101);
      vecs[2]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b101, 0, 0, 0, 12'h123, 3'b101);
      vecs[3]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 0, 0, 0, 12'h123, 3'b101);
      vecs[4]  = mk(0, 3'b111, 3'b111, 3'b100, 3'b000, 3'b101, 1, 1, 1, 12'hFFF, 3'b110);
      vecs[5]  = mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 0, 0, 0, 12'hFFF, 3'b110);
      vecs[6]  = mk(0, 3'b111, 3'b111, 3'b001, 3'b000, 3'b101, 1, 1, 1, 12'h00A, 3'b011);
      vecs[7]  = mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 0, 0, 0, 12'h00A, 3'b011);
      vecs[8]  = mk(0, 3'b111, 3'b111, 3'b010, 3'b000, 3'b101, 1, 1, 1, 12'h123, 3'b101);
      vecs[9]  = mk(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 0, 0, 0, 12'h123, 3'b101);
      vecs[10] = mk(0, 3'b111, 3'b111, 3'b100, 3'b000, 3'b101, 1, 1, 1, 12'hFFF, 3'b110);
      vecs[11] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 0, 0, 0, 12'hFFF, 3'b110);
      vecs[12] = mk(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b101, 1, 1, 0, 12'h00A, 3'b011);
      vecs[13] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 1, 0, 0, 12'h00A, 3'b011);
      vecs[14] = mk(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 0, 0, 0, 12'h00A, 3'b011);
      vecs[15] = mk(0, 3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 1, 1, 1, 12'hFFF, 3'b110);
      vecs[16] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 0, 0, 0, 12'hFFF, 3'b110);
      vecs[17] = mk(1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b100, 0, 0, 0, 12'hFFF, 3'b110);
      vecs[18] = mk(0, 3'b011, 3'b000, 3'b001, 3'b000, 3'b100, 1, 1, 0, 12'h00A, 3'b011);
      vecs[19] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 1, 0, 0, 12'h00A, 3'b011);
      vecs[20] = mk(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 0, 0, 0, 12'h00A, 3'b011);

      // Reset with random inputs: everything stays 0.
      for (int i = 0; i < 4; i++) begin
         req  = 3'($urandom); we  = 3'($urandom); halt  = 1'($urandom);
         req3 = 3'($urandom); we3 = 3'($urandom); halt3 = 1'($urandom);
         step();
         check($sformatf("reset_rand%0d", i), obs1(), 27'd0);
         check($sformatf("reset_rand3_%0d", i), obs3(), 27'd0);
      end
      req = 3'b000; we = 3'b000; halt = 1'b0;
      req3 = 3'b000; we3 = 3'b000; halt3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("post_reset_idle%0d", i), obs1(), 27'd0);
      end

      // Table: read, round-robin writes, read-then-back-to-back, halt.
      for (int i = 0; i < 21; i++) begin
         halt = vecs[i].halt;
         req  = vecs[i].req;
         we   = vecs[i].we;
         step();
         check($sformatf("vec%0d", i), obs1(),
               pack(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].busy,
                    vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata));
      end

      // Halt raised during WAIT: rvalid still pulses, no grant while halted.
      // ptr = 1 here.
      req = 3'b010; we = 3'b000;
      step();
      check("halt_gnt1", obs1(), pack(3'b010, 3'b000, 3'b100, 1, 1, 0, 12'h123, 3'b101));
      req = 3'b000;
      step();
      halt = 1'b1; req = 3'b101;
      step();
      check("halt_rvalid", obs1(), pack(3'b000, 3'b010, 3'b101, 0, 0, 0, 12'h123, 3'b101));
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("halt_hold%0d", i), obs1(),
               pack(3'b000, 3'b000, 3'b101, 0, 0, 0, 12'h123, 3'b101));
      end
      halt = 1'b0;
      step();
      check("halt_release_gnt", obs1(), pack(3'b100, 3'b000, 3'b101, 1, 1, 0, 12'hFFF, 3'b110));
      req = 3'b000;
      step();
      step();
      check("halt_release_rvalid", obs1(), pack(3'b000, 3'b100, 3'b001, 0, 0, 0, 12'hFFF, 3'b110));

      // Reset during WAIT: abandon access, ptr returns to 0. ptr = 0 here.
      req = 3'b010; we = 3'b000;
      step();
      check("rst_mid_gnt", obs1(), pack(3'b010, 3'b000, 3'b001, 1, 1, 0, 12'h123, 3'b101));
      req = 3'b000;
      step();
      check("rst_mid_wait", obs1(), pack(3'b000, 3'b000, 3'b001, 1, 0, 0, 12'h123, 3'b101));
      rst_n = 1'b0;
      #1;
      check("rst_mid_async", obs1(), 27'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_mid_no_rvalid", obs1(), 27'd0);
      req = 3'b110; we = 3'b000;
      step();
      check("rst_mid_ptr0", obs1(), pack(3'b010, 3'b000, 3'b000, 1, 1, 0, 12'h123, 3'b101));
      req = 3'b000;
      step();
      step();
      check("rst_mid_read_after", obs1(), pack(3'b000, 3'b010, 3'b101, 0, 0, 0, 12'h123, 3'b101));

      // MEM_LAT = 3 read on dut3: gnt cycle 1, WAIT 2-4, rvalid cycle 5.
      req3 = 3'b001; we3 = 3'b000;
      step();
      check("lat3_gnt", obs3(), pack(3'b001, 3'b000, 3'b000, 1, 1, 0, 12'h055, 3'b000));
      req3 = 3'b000;
      for (int i = 2; i <= 4; i++) begin
         step();
         check($sformatf("lat3_wait%0d", i), obs3(),
               pack(3'b000, 3'b000, 3'b000, 1, 0, 0, 12'h055, 3'b000));
      end
      step();
      check("lat3_rvalid", obs3(), pack(3'b000, 3'b001, 3'b011, 0, 0, 0, 12'h055, 3'b000));
      step();
      check("lat3_hold", obs3(), pack(3'b000, 3'b000, 3'b011, 0, 0, 0, 12'h055, 3'b000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
